window_gen: RTL

Parametrised streaming sliding-window generator for the CNN1 convolution datapath. It accepts a raster-order pixel stream with a valid/ready handshake and stores K-1 previous rows in line buffers. It emits one K×K window per output position, with configurable stride, together with output coordinates and an end-of-frame flag. It sits between the pixel source (input image memory or previous layer) and the convolution MAC array, and generalises the fixed 3×3, width-28, no-backpressure line buffer.

---
 rtl/window_gen_if.sv | 31 +++
 rtl/window_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/window_gen_if.sv
// Pixel-in / window-out stream bundle for window_gen.
//   in_data/in_valid/in_ready : raster-order pixel stream into the generator
//   win_data/win_valid/win_ready, win_row/win_col/win_last : K x K window stream out
// slave  : the window generator side (consumes pixels, produces windows)
// master : the surrounding logic (produces pixels, consumes windows)
interface window_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int ROW_W      = 5,
    parameter int COL_W      = 5
);
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [K*K*DATA_WIDTH-1:0] win_data;
    logic                      win_valid;
    logic                      win_ready;
    logic [ROW_W-1:0]          win_row;
    logic [COL_W-1:0]          win_col;
    logic                      win_last;

    modport master (
        output in_data, in_valid, win_ready,
        input  in_ready, win_data, win_valid, win_row, win_col, win_last
    );

    modport slave (
        input  in_data, in_valid, win_ready,
        output in_ready, win_data, win_valid, win_row, win_col, win_last
    );
endinterface

// File: rtl/window_gen.sv
// Streaming K x K sliding-window generator with stride.
//   clk   : rising-edge clock for all state
//   rst   : synchronous active-high reset
//   clear : synchronous frame restart (counters and outputs zeroed, line buffers kept)
//   bus   : window_gen_if.slave, pixel stream in and window stream out
// Window element (r,c) sits at win_data[(r*K+c)*DATA_WIDTH +: DATA_WIDTH], r=0 oldest row.
module window_gen #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int STRIDE     = 1
) (
    input logic         clk,
    input logic         rst,
    input logic         clear,
    window_gen_if.slave bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WIN_W = K * K * DATA_WIDTH;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(STRIDE - 1);
    localparam logic [COL_W-1:0] OCOL_LAST = COL_W'((IMG_WIDTH - K) / STRIDE);
    localparam logic [ROW_W-1:0] OROW_LAST = ROW_W'((IMG_HEIGHT - K) / STRIDE);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    // Input position, stride phase and output-map position trackers.
    logic [COL_W-1:0] col_q, col_d, ocol_q, ocol_d;
    logic [ROW_W-1:0] row_q, row_d, orow_q, orow_d;
    logic [PH_W-1:0]  cph_q, cph_d, rph_q, rph_d;

    pix_t sr_q [K][K];
    pix_t sr_d [K][K];
    pix_t lb_q [K-1][IMG_WIDTH];
    pix_t new_col [K];

    logic [WIN_W-1:0] win_data_q, win_data_d;
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;

    logic in_ready;
    logic xfer;
    logic emit;

    always_comb begin
        in_ready = !rst && !clear && (!win_valid_q || bus.win_ready);
        xfer     = bus.in_valid && in_ready;

        // Line buffer j holds row-1-j, so the oldest row comes from the last buffer.
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = lb_q[K-2-r][col_q];
        end
        new_col[K-1] = bus.in_data;

        col_d  = col_q;
        row_d  = row_q;
        cph_d  = cph_q;
        rph_d  = rph_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        sr_d   = sr_q;

        win_data_d  = win_data_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;

        // Phases are only meaningful once the window fits; they sit at 0 before that.
        emit = xfer && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST)
               && (cph_q == '0) && (rph_q == '0);

        if (xfer) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    sr_d[r][c] = sr_q[r][c+1];
                end
                sr_d[r][K-1] = new_col[r];
            end

            if (col_q == COL_LAST) begin
                col_d  = '0;
                cph_d  = '0;
                ocol_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    rph_d  = '0;
                    orow_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q >= ROW_FIRST) begin
                        if (rph_q == PH_LAST) begin
                            rph_d  = '0;
                            orow_d = orow_q + 1'b1;
                        end else begin
                            rph_d = rph_q + 1'b1;
                        end
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (col_q >= COL_FIRST) begin
                    if (cph_q == PH_LAST) begin
                        cph_d  = '0;
                        ocol_d = ocol_q + 1'b1;
                    end else begin
                        cph_d = cph_q + 1'b1;
                    end
                end
            end
        end

        if (emit) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_data_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = sr_d[r][c];
                end
            end
            win_valid_d = 1'b1;
            win_row_d   = orow_q;
            win_col_d   = ocol_q;
            win_last_d  = (orow_q == OROW_LAST) && (ocol_q == OCOL_LAST);
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            cph_q       <= '0;
            rph_q       <= '0;
            ocol_q      <= '0;
            orow_q      <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    sr_q[r][c] <= '0;
                end
            end
        end else if (clear) begin
            col_q       <= '0;
            row_q       <= '0;
            cph_q       <= '0;
            rph_q       <= '0;
            ocol_q      <= '0;
            orow_q      <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            cph_q       <= cph_d;
            rph_q       <= rph_d;
            ocol_q      <= ocol_d;
            orow_q      <= orow_d;
            sr_q        <= sr_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    // Line buffer RAM: no reset, stale contents are masked by the row gating.
    always_ff @(posedge clk) begin
        if (xfer) begin
            lb_q[0][col_q] <= bus.in_data;
            for (int j = 1; j < K - 1; j++) begin
                lb_q[j][col_q] <= lb_q[j-1][col_q];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.win_data  = win_data_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_last  = win_last_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
endmodule
